// File: rtl/patbuf_pkg.sv
// patbuf_pkg: shared types and constants for the pattern scheduler.
//   - state_e      : scheduler FSM states
//   - ENT_*        : bit positions of a sequence-entry byte
//   - seq_entry_t  : decoded sequence entry (valid, repeat count, buffer index)
//   - *_DEF        : default geometry (fields per buffer, sequence length)
package patbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int FIELDS_DEF  = 27;
    localparam int SEQ_LEN_DEF = 3;

    // Entry byte: [7] valid, [6:3] repeat count R (plays R+1 times), [2:0] buffer
    localparam int ENT_VALID_BIT = 7;
    localparam int ENT_RPT_LSB   = 3;
    localparam int ENT_RPT_W     = 4;
    localparam int ENT_BUF_LSB   = 0;
    localparam int ENT_BUF_W     = 3;

    typedef struct packed {
        logic                 valid;
        logic [ENT_RPT_W-1:0] rpt;
        logic [ENT_BUF_W-1:0] bufi;
    } seq_entry_t;

endpackage

// File: rtl/seq_entry_decode.sv
// seq_entry_decode: combinational split of one sequence-entry byte.
//   entry : in  8-bit raw entry
//   dec   : out decoded {valid, repeat count, buffer index}
module seq_entry_decode
    import patbuf_pkg::*;
(
    input  logic [7:0]  entry,
    output seq_entry_t  dec
);

    always_comb begin
        dec.valid = entry[ENT_VALID_BIT];
        dec.rpt   = entry[ENT_RPT_LSB +: ENT_RPT_W];
        dec.bufi  = entry[ENT_BUF_LSB +: ENT_BUF_W];
    end

endmodule

// File: rtl/pattern_scheduler.sv
// pattern_scheduler: walks a snapshot of pattern_sequence, drives bufp/fieldp
// into the buffer block and presents each returned field_byte on a
// valid/ready stream. Reads never advance while ssel (serial load) is high.
//
// Ports:
//   sclk, rst            : clock, async active-high reset
//   start, stop          : begin playback (IDLE only) / abort (any busy state)
//   ssel                 : serial load in progress, pauses FETCH
//   pattern_sequence     : SEQ_LEN entry bytes, entry i at [8i+7:8i]
//   field_byte           : buffer read data for current bufp/fieldp
//   out_ready            : downstream accepts field_out
//   bufp, fieldp         : buffer / field pointers
//   field_out/valid      : captured field and its valid
//   seq_idx, busy, done  : current entry, non-IDLE flag, completion pulse
//
// Optional feature macro PATSCHED_LOOP_EN adds input `loop`: when high, the
// end of the sequence restarts at entry 0 of the same snapshot and done
// pulses once per pass.
module pattern_scheduler
    import patbuf_pkg::*;
#(
    parameter int FIELDS  = FIELDS_DEF,
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int FIELD_W = 5,
    parameter int BUF_W   = 3,
    localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   ssel,
`ifdef PATSCHED_LOOP_EN
    input  logic                   loop,
`endif
    input  logic [8*SEQ_LEN-1:0]   pattern_sequence,
    input  logic [7:0]             field_byte,
    input  logic                   out_ready,
    output logic [BUF_W-1:0]       bufp,
    output logic [FIELD_W-1:0]     fieldp,
    output logic [7:0]             field_out,
    output logic                   field_valid,
    output logic [IDX_W-1:0]       seq_idx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [FIELD_W-1:0] LAST_FIELD = FIELD_W'(FIELDS - 1);

    logic loop_en;
`ifdef PATSCHED_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [8*SEQ_LEN-1:0]   snap_q, snap_d;
    logic [BUF_W-1:0]       bufp_q, bufp_d;
    logic [FIELD_W-1:0]     fieldp_q, fieldp_d;
    logic [ENT_RPT_W-1:0]   rpt_q, rpt_d;
    logic [IDX_W-1:0]       seq_idx_q, seq_idx_d;
    logic [7:0]             field_out_q, field_out_d;
    logic                   field_valid_q, field_valid_d;
    logic                   done_q, done_d;

    // Current and following entry of the snapshot; past the end reads as 0
    // (invalid), which folds "index == SEQ_LEN" into the invalid-entry check.
    logic [7:0] cur_byte, nxt_byte;
    always_comb begin
        cur_byte = snap_q[8*int'(seq_idx_q) +: 8];
        nxt_byte = 8'h00;
        if (int'(seq_idx_q) + 1 < SEQ_LEN)
            nxt_byte = snap_q[8*(int'(seq_idx_q) + 1) +: 8];
    end

    seq_entry_t cur_dec, nxt_dec, start_dec;
    seq_entry_decode u_cur_dec   (.entry(cur_byte),              .dec(cur_dec));
    seq_entry_decode u_nxt_dec   (.entry(nxt_byte),              .dec(nxt_dec));
    // Entry 0 of the live input: the snapshot is only written at this edge.
    seq_entry_decode u_start_dec (.entry(pattern_sequence[7:0]), .dec(start_dec));

    // State register
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            snap_q        <= '0;
            bufp_q        <= '0;
            fieldp_q      <= '0;
            rpt_q         <= '0;
            seq_idx_q     <= '0;
            field_out_q   <= '0;
            field_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            snap_q        <= snap_d;
            bufp_q        <= bufp_d;
            fieldp_q      <= fieldp_d;
            rpt_q         <= rpt_d;
            seq_idx_q     <= seq_idx_d;
            field_out_q   <= field_out_d;
            field_valid_q <= field_valid_d;
            done_q        <= done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        bufp_d        = bufp_q;
        fieldp_d      = fieldp_q;
        rpt_d         = rpt_q;
        seq_idx_d     = seq_idx_q;
        field_out_d   = field_out_q;
        field_valid_d = field_valid_q;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !ssel) begin
                    snap_d = pattern_sequence;
                    if (start_dec.valid) begin
                        seq_idx_d = '0;
                        bufp_d    = BUF_W'(start_dec.bufi);
                        fieldp_d  = '0;
                        rpt_d     = '0;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_FETCH: begin
                if (!ssel) begin
                    field_out_d   = field_byte;
                    field_valid_d = 1'b1;
                    state_d       = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (out_ready) begin
                    field_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                    if (fieldp_q != LAST_FIELD) begin
                        fieldp_d = fieldp_q + 1'b1;
                    end else begin
                        fieldp_d = '0;
                        if (rpt_q < cur_dec.rpt) begin
                            rpt_d = rpt_q + 1'b1;
                        end else if (!nxt_dec.valid) begin
                            // End of sequence: pointers keep the last entry.
                            done_d = 1'b1;
                            if (loop_en) begin
                                seq_idx_d = '0;
                                bufp_d    = BUF_W'(snap_q[ENT_BUF_LSB +: ENT_BUF_W]);
                                rpt_d     = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            seq_idx_d = seq_idx_q + 1'b1;
                            bufp_d    = BUF_W'(nxt_dec.bufi);
                            rpt_d     = '0;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;  // ST_DONE
        endcase

        // Abort wins over everything but still lets an EMIT transfer count.
        if (stop && state_q != ST_IDLE) begin
            state_d       = ST_IDLE;
            field_valid_d = 1'b0;
            done_d        = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        bufp        = bufp_q;
        fieldp      = fieldp_q;
        field_out   = field_out_q;
        field_valid = field_valid_q;
        seq_idx     = seq_idx_q;
        busy        = (state_q != ST_IDLE);
        done        = done_q;
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: table-driven sequences checked
// against a transfer-list model, plus directed multi-cycle corner cases.
module tb_pattern_scheduler;

    logic        sclk = 1'b0;
    logic        rst;
    logic        start, stop, ssel, out_ready;
    logic [23:0] seq_in;
    logic [7:0]  field_byte;
    logic [2:0]  bufp;
    logic [4:0]  fieldp;
    logic [7:0]  field_out;
    logic        field_valid;
    logic [1:0]  seq_idx;
    logic        busy, done;
`ifdef PATSCHED_LOOP_EN
    logic        loop = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 sclk = ~sclk;

    pattern_scheduler dut (
        .sclk(sclk), .rst(rst), .start(start), .stop(stop), .ssel(ssel),
`ifdef PATSCHED_LOOP_EN
        .loop(loop),
`endif
        .pattern_sequence(seq_in), .field_byte(field_byte), .out_ready(out_ready),
        .bufp(bufp), .fieldp(fieldp), .field_out(field_out), .field_valid(field_valid),
        .seq_idx(seq_idx), .busy(busy), .done(done)
    );

    // Buffer contents: distinct byte per (buffer, field), readable same cycle.
    function automatic logic [7:0] mem_byte(input logic [2:0] b, input logic [4:0] f);
        return {b, f} ^ 8'h5A;
    endfunction
    assign field_byte = mem_byte(bufp, fieldp);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    typedef struct { logic [2:0] b; logic [4:0] f; } xfer_t;
    typedef struct { logic [23:0] seq; int rdy; int sp; int exp_n; } vec_t;

    // Expected transfer list straight from the entry rules.
    function automatic void build_model(input logic [23:0] s, ref xfer_t q[$]);
        q.delete();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e;
            e = s[8*i +: 8];
            if (!e[7]) break;
            for (int r = 0; r <= int'(e[6:3]); r++)
                for (int f = 0; f < 27; f++) begin
                    xfer_t x;
                    x.b = e[2:0];
                    x.f = 5'(f);
                    q.push_back(x);
                end
        end
    endfunction

    task automatic run_seq(input logic [23:0] s, input int rdy, input int sp, input int exp_n);
        xfer_t q[$];
        int n = 0, last = -1, want;
        bit got_done = 0, prev_hold = 0;
        logic [7:0] prev_out = 8'h00;
        build_model(s, q);
        want = (exp_n < 0) ? q.size() : exp_n;
        seq_in = s; ssel = 1'b0; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20000 && !got_done; c++) begin
            if (prev_hold) begin
                chk("hold_valid", field_valid, 1);
                chk("hold_data", field_out, prev_out);
            end
            if (done) begin
                got_done = 1;
                chk("done_timing", c, last + 1);
                chk("model_empty_at_done", q.size(), 0);
            end else begin
                out_ready = (($urandom % 100) < rdy);
                ssel      = (($urandom % 100) < sp);
                prev_hold = field_valid && !out_ready;
                prev_out  = field_out;
                if (field_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("extra_transfer", n, want);
                    end else begin
                        xfer_t h;
                        h = q.pop_front();
                        chk("xfer", {bufp, fieldp, field_out}, {h.b, h.f, mem_byte(h.b, h.f)});
                    end
                    n++;
                    last = c;
                end
                tick();
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        chk("xfer_count", n, want);
        out_ready = 1'b0; ssel = 1'b0;
        tick();
        chk("idle_after_done", {busy, done}, 2'b00);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{24'h008281, 100, 0,  54};
        tbl[1] = '{24'h00008B, 100, 0,  54};
        tbl[2] = '{24'h000000, 100, 0,   0};
        tbl[3] = '{24'h9E808D,  50, 10, 189};
        tbl[4] = '{24'h870084,  60, 20,  27};
        tbl[5] = '{24'h000000,  70, 15,  -1};
        tbl[5].seq = 24'($urandom);

        rst = 1'b1; start = 0; stop = 0; ssel = 0; out_ready = 0; seq_in = '0;
        tick(); tick();
        chk("rst_outputs", {bufp, fieldp, field_out, field_valid, seq_idx, busy, done}, '0);
        @(negedge sclk); rst = 1'b0;
        tick();
        chk("idle_after_rst", busy, 0);

        for (int i = 0; i < 6; i++) run_seq(tbl[i].seq, tbl[i].rdy, tbl[i].sp, tbl[i].exp_n);

        // Latency, out_ready stall, ssel pause, stop with transfer
        seq_in = 24'h000081; start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_fetch_valid", {busy, field_valid}, 2'b10);
        tick();
        chk("lat_emit", {field_valid, field_out}, {1'b1, mem_byte(3'd1, 5'd0)});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", {field_valid, field_out, fieldp}, {1'b1, mem_byte(3'd1, 5'd0), 5'd0});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; ssel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ssel_pause", {field_valid, fieldp}, {1'b0, 5'd1});
        end
        ssel = 1'b0;
        tick();
        chk("ssel_resume", {field_valid, fieldp, field_out}, {1'b1, 5'd1, mem_byte(3'd1, 5'd1)});
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !(field_valid && fieldp == 5'd10); i++) tick();
        chk("reach_field10", {field_valid, fieldp}, {1'b1, 5'd10});
        stop = 1'b1;
        tick();
        stop = 1'b0; out_ready = 1'b0;
        chk("stop_idle", {busy, field_valid, fieldp}, {1'b0, 1'b0, 5'd11});
        begin
            int dcnt = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (done) dcnt++;
            end
            chk("stop_no_done", dcnt, 0);
        end

        // start while ssel high is dropped, not queued
        ssel = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; ssel = 1'b0;
        chk("start_ssel_ignored", busy, 0);
        tick();
        chk("start_not_queued", busy, 0);

        // Async reset in EMIT
        seq_in = 24'h000083; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_emit", {field_valid, bufp}, {1'b1, 3'd3});
        #2 rst = 1'b1;
        #1 chk("async_rst", {bufp, fieldp, field_out, field_valid, seq_idx, busy, done}, '0);
        #1 rst = 1'b0;
        tick();

`ifdef PATSCHED_LOOP_EN
        begin
            int n = 0, dcnt = 0;
            loop = 1'b1; seq_in = 24'h000080; start = 1'b1; out_ready = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 1000 && n < 81; c++) begin
                if (done) dcnt++;
                if (field_valid) begin
                    chk("loop_xfer", {bufp, fieldp}, {3'd0, 5'(n % 27)});
                    n++;
                end
                tick();
            end
            if (done) dcnt++;
            chk("loop_count", n, 81);
            chk("loop_done_pulses", dcnt, 3);
            chk("loop_still_busy", busy, 1);
            stop = 1'b1; loop = 1'b0; out_ready = 1'b0;
            tick();
            stop = 1'b0;
            chk("loop_stop", busy, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
